// File: rtl/sid_pkg.sv
// Shared audio types and constants for the serial audio blocks.
package sid;

  localparam int unsigned SAMPLE_W  = 24;
  localparam int unsigned I2S_SLOTS = 64;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } audio_t;

  // 64-slot I2S frame: each 24-bit channel left-justified in a 32-slot half.
  function automatic logic [I2S_SLOTS-1:0] frame_word(input audio_t a);
    return {a.left, 8'h00, a.right, 8'h00};
  endfunction

endpackage

// File: rtl/i2s_tx.sv
// I2S transmitter: stereo 24-bit samples serialised into 64-slot frames,
// with bclk derived from clk by a programmable half-period divider.
module i2s_tx
  import sid::*;
#(
  parameter int unsigned BCLK_HALF = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  audio_t audio_i,
  input  logic   audio_valid,
  output logic   i2s_bclk,
  output logic   i2s_lrclk,
  output logic   i2s_sdata,
  output logic   sample_req
);

  localparam int unsigned DIV_W   = 8;
  localparam int unsigned SLOT_W  = $clog2(I2S_SLOTS);
  localparam int unsigned FRAME_W = I2S_SLOTS;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);

  logic [DIV_W-1:0]   div;
  logic [SLOT_W-1:0]  slot;
  logic [SLOT_W-1:0]  slot_nxt_c;
  logic [FRAME_W-1:0] shreg;
  audio_t             hold;
  logic               div_wrap_c;

  assign div_wrap_c = (div == DIV_LAST);
  assign slot_nxt_c = slot + SLOT_W'(1);

  // Divider, slot counter, holding and shift registers; everything moves on bclk fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div        <= '0;
      slot       <= '1;
      shreg      <= '0;
      hold       <= '0;
      i2s_bclk   <= 1'b0;
      i2s_lrclk  <= 1'b1;
      i2s_sdata  <= 1'b0;
      sample_req <= 1'b0;
    end else begin
      sample_req <= 1'b0;
      if (audio_valid) begin
        hold <= audio_i;
      end
      if (div_wrap_c) begin
        div      <= '0;
        i2s_bclk <= ~i2s_bclk;
        if (i2s_bclk) begin
          slot      <= slot_nxt_c;
          i2s_lrclk <= slot_nxt_c[SLOT_W-1];
          // Snapshot reads the pre-write hold value, so a coincident strobe lands next frame.
          if (slot_nxt_c == '0) begin
            shreg      <= frame_word(hold);
            i2s_sdata  <= 1'b0;
            sample_req <= 1'b1;
          end else begin
            i2s_sdata <= shreg[FRAME_W-1];
            shreg     <= {shreg[FRAME_W-2:0], 1'b0};
          end
        end
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: frame scoreboard on a BCLK_HALF=4 instance, plus a
// BCLK_HALF=1 instance checked for rate and bit layout.
module tb_i2s_tx;
  import sid::*;

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
  } exp_t;

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic [23:0] exp_l;
    logic [23:0] exp_r;
  } vec_t;

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  audio_t audio;
  logic   audio_valid = 1'b0;
  logic   bclk0, lrclk0, sdata0, sreq0;
  logic   bclk1, lrclk1, sdata1, sreq1;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   frames0 = 0;
  bit   mon1_done = 1'b0;
  exp_t exp_q[$];
  exp_t exp_q1[$];

  i2s_tx #(.BCLK_HALF(4)) dut0 (
    .clk(clk), .rst(rst), .audio_i(audio), .audio_valid(audio_valid),
    .i2s_bclk(bclk0), .i2s_lrclk(lrclk0), .i2s_sdata(sdata0), .sample_req(sreq0)
  );

  i2s_tx #(.BCLK_HALF(1)) dut1 (
    .clk(clk), .rst(rst), .audio_i(audio), .audio_valid(audio_valid),
    .i2s_bclk(bclk1), .i2s_lrclk(lrclk1), .i2s_sdata(sdata1), .sample_req(sreq1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Collected word holds the bit seen at slot k in position 63-k.
  task automatic check_frame(input string tag, input logic [63:0] sw, input logic [63:0] lw,
                             input exp_t e);
    check({tag, " slot0"}, 64'(sw[63]), 64'd0);
    check({tag, " left"},  64'(sw[62:39]), 64'(e.l));
    check({tag, " pad1"},  64'(sw[38:31]), 64'd0);
    check({tag, " right"}, 64'(sw[30:7]), 64'(e.r));
    check({tag, " pad2"},  64'(sw[6:0]), 64'd0);
    check({tag, " lrclk"}, lw, 64'h0000_0000_FFFF_FFFF);
  endtask

  task automatic drive(input logic [23:0] l, input logic [23:0] r);
    audio.left  = l;
    audio.right = r;
    audio_valid = 1'b1;
    @(posedge clk);
    #1;
    audio_valid = 1'b0;
  endtask

  task automatic wait_sreq();
    bit got = 1'b0;
    for (int t = 0; t < 2000 && !got; t++) begin
      @(posedge clk);
      #1;
      if (sreq0) got = 1'b1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL wait_sreq: no sample_req within 2000 clk, want one");
    end
  endtask

  // Frame collector / scoreboard for the BCLK_HALF=4 instance.
  initial begin : mon0
    logic [63:0] sw, lw;
    int          nbits, last;
    bit          coll;
    logic        pb;
    exp_t        e;
    sw = '0; lw = '0; nbits = 0; last = -1; coll = 1'b0; pb = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        coll = 1'b0;
        pb   = 1'b0;
        last = -1;
      end else begin
        if (bclk0 && !pb && coll) begin
          sw = {sw[62:0], sdata0};
          lw = {lw[62:0], lrclk0};
          nbits++;
        end
        pb = bclk0;
        if (sreq0) begin
          if (coll) begin
            check("bits0", 64'(nbits), 64'd64);
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL scoreboard0: frame seen with empty queue, want a queued expectation");
            end else begin
              e = exp_q.pop_front();
              check_frame("frame0", sw, lw, e);
            end
            frames0++;
          end
          if (last >= 0) check("period0", 64'(cyc - last), 64'd512);
          last  = cyc;
          coll  = 1'b1;
          nbits = 0;
        end
      end
    end
  end

  // BCLK_HALF=1 instance: first frame layout and two frame periods.
  initial begin : mon1
    logic [63:0] sw, lw;
    int          seen, last;
    logic        pb;
    exp_t        e;
    sw = '0; lw = '0; seen = 0; last = 0; pb = 1'b0;
    wait (rst == 1'b1);
    wait (rst == 1'b0);
    for (int t = 0; t < 1000 && seen < 3; t++) begin
      @(negedge clk);
      if (bclk1 && !pb && seen == 1) begin
        sw = {sw[62:0], sdata1};
        lw = {lw[62:0], lrclk1};
      end
      pb = bclk1;
      if (sreq1) begin
        if (seen == 1) begin
          if (exp_q1.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard1: frame seen with empty queue, want a queued expectation");
          end else begin
            e = exp_q1.pop_front();
            check_frame("frame1", sw, lw, e);
          end
        end
        if (seen >= 1) check("period1", 64'(cyc - last), 64'd128);
        last = cyc;
        seen++;
      end
    end
    if (seen < 3) begin
      total++;
      bad++;
      $display("FAIL mon1: saw %0d sample_req pulses, want 3", seen);
    end
    mon1_done = 1'b1;
  end

  initial begin : stim
    vec_t vecs[4];
    vecs[0] = '{24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h000000};
    vecs[1] = '{24'hAAAAAA, 24'h555555, 24'hAAAAAA, 24'h555555};
    vecs[2] = '{24'h000001, 24'h800000, 24'h000001, 24'h800000};
    vecs[3] = '{24'h5A0F3C, 24'hC3F0A5, 24'h5A0F3C, 24'hC3F0A5};
    audio = '0;

    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst bclk0",  64'(bclk0),  64'd0);
    check("rst lrclk0", 64'(lrclk0), 64'd1);
    check("rst sdata0", 64'(sdata0), 64'd0);
    check("rst sreq0",  64'(sreq0),  64'd0);
    check("rst bclk1",  64'(bclk1),  64'd0);
    check("rst lrclk1", 64'(lrclk1), 64'd1);

    // First sample lands before the first slot 0 of both instances.
    @(negedge clk);
    rst = 1'b0;
    audio.left  = 24'h800001;
    audio.right = 24'h7FFFFE;
    audio_valid = 1'b1;
    exp_q.push_back('{24'h800001, 24'h7FFFFE});
    exp_q1.push_back('{24'h800001, 24'h7FFFFE});
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) audio_valid = 1'b0;
      check($sformatf("start bclk c%0d", c),  64'(bclk0),  64'(c >= 4 && c < 8));
      check($sformatf("start sreq c%0d", c),  64'(sreq0),  64'(c == 8));
      check($sformatf("start lrclk c%0d", c), 64'(lrclk0), 64'(c < 8));
    end

    // One sample per frame; each shows up in the following frame.
    for (int i = 0; i < 4; i++) begin
      repeat (50) @(posedge clk);
      #1;
      drive(vecs[i].l, vecs[i].r);
      exp_q.push_back('{vecs[i].exp_l, vecs[i].exp_r});
      wait_sreq();
    end

    // Strobe in the snapshot cycle: current frame repeats the old sample.
    repeat (511) @(posedge clk);
    #1;
    audio.left  = 24'h123456;
    audio.right = 24'h654321;
    audio_valid = 1'b1;
    @(posedge clk);
    #1;
    check("coincident sreq", 64'(sreq0), 64'd1);
    audio_valid = 1'b0;
    exp_q.push_back('{vecs[3].exp_l, vecs[3].exp_r});
    exp_q.push_back('{24'h123456, 24'h654321});
    wait_sreq();

    // Three strobes in one frame, then three silent frames.
    for (int i = 1; i <= 3; i++) begin
      repeat (20) @(posedge clk);
      #1;
      drive(24'(i), 24'hABCDE0 + 24'(i));
    end
    repeat (3) exp_q.push_back('{24'h000003, 24'hABCDE3});
    repeat (4) wait_sreq();

    // Reset in the high half of slot 40, where sdata carries right[16] = 1.
    repeat (325) @(posedge clk);
    #1;
    check("slot40 sdata", 64'(sdata0), 64'd1);
    check("slot40 bclk",  64'(bclk0),  64'd1);
    rst = 1'b1;
    #1;
    check("midrst bclk",  64'(bclk0),  64'd0);
    check("midrst lrclk", 64'(lrclk0), 64'd1);
    check("midrst sdata", 64'(sdata0), 64'd0);
    check("midrst sreq",  64'(sreq0),  64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back('{24'h000000, 24'h000000});
    repeat (2) wait_sreq();
    repeat (4) @(posedge clk);
    #1;
    check("queue drained", 64'(exp_q.size()), 64'd0);
    check("frames0 count", 64'(frames0), 64'd11);
    if (!mon1_done) begin
      total++;
      bad++;
      $display("FAIL mon1_done: got 0 want 1");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
